// File: rtl/pbch_re_demapper_if.sv
// Stream bundle for the PBCH RE demapper: SSB RE input plus LLR and DMRS outputs.
interface pbch_re_demapper_if #(
    parameter int unsigned IN_DW  = 32,
    parameter int unsigned LLR_DW = 8
);
    logic [IN_DW-1:0]    s_axis_in_tdata;
    logic                s_axis_in_tvalid;
    logic [2*LLR_DW-1:0] m_axis_llr_tdata;
    logic                m_axis_llr_tvalid;
    logic                m_axis_llr_tlast;
    logic [IN_DW-1:0]    m_axis_dmrs_tdata;
    logic                m_axis_dmrs_tvalid;
    logic [7:0]          m_axis_dmrs_idx_o;

    // master: upstream/consumer side; slave: the demapper itself
    modport master (
        output s_axis_in_tdata, s_axis_in_tvalid,
        input  m_axis_llr_tdata, m_axis_llr_tvalid, m_axis_llr_tlast,
        input  m_axis_dmrs_tdata, m_axis_dmrs_tvalid, m_axis_dmrs_idx_o
    );
    modport slave (
        input  s_axis_in_tdata, s_axis_in_tvalid,
        output m_axis_llr_tdata, m_axis_llr_tvalid, m_axis_llr_tlast,
        output m_axis_dmrs_tdata, m_axis_dmrs_tvalid, m_axis_dmrs_idx_o
    );
endinterface

// File: rtl/pbch_re_demapper.sv
// Splits SSB symbols 1..3 into PBCH DMRS REs and PBCH data LLR pairs, dropping SSS/guard REs.
module pbch_re_demapper #(
    parameter int unsigned IN_DW  = 32,
    parameter int unsigned LLR_DW = 8,
    parameter int unsigned N_SC   = 240
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [9:0] N_id_i,
    input  logic       N_id_valid_i,
    input  logic       PBCH_start_i,
    pbch_re_demapper_if.slave bus,
    output logic       done_o,
    output logic       abort_o
);
    localparam int unsigned HALF   = IN_DW / 2;
    localparam int unsigned N_DATA = 432;
    localparam int unsigned SSS_LO = 48;
    localparam int unsigned SSS_HI = 191;

    typedef enum logic [2:0] {IDLE, SYM1, SYM2, SYM3, DONE} state_t;

    state_t     state;
    logic [9:0] nid_q;
    logic       nid_ok;
    logic [1:0] v_q;
    logic [7:0] sc_cnt;
    logic [8:0] data_cnt;
    logic [7:0] dmrs_cnt;

    logic       in_block_c, start_c, proc_c, pbch_c, dmrs_c;
    state_t     sym_c, next_sym_c;
    logic [7:0] k_c, mcnt_c;
    logic [1:0] v_c;
    logic [8:0] dcnt_c;

    // Only N_id mod 4 steers the DMRS comb; the rest of the id is kept for visibility.
    wire unused_nid = &{1'b0, nid_q[9:2]};

    assign in_block_c = (state == SYM1) || (state == SYM2) || (state == SYM3);
    assign start_c    = PBCH_start_i && bus.s_axis_in_tvalid && nid_ok;
    assign proc_c     = start_c || (in_block_c && bus.s_axis_in_tvalid);

    // A start pulse makes the current RE sc 0 of a fresh symbol 1 with cleared counters.
    always_comb begin
        sym_c  = state;
        k_c    = sc_cnt;
        v_c    = v_q;
        dcnt_c = data_cnt;
        mcnt_c = dmrs_cnt;
        if (start_c) begin
            sym_c  = SYM1;
            k_c    = '0;
            v_c    = nid_q[1:0];
            dcnt_c = '0;
            mcnt_c = '0;
        end
    end

    always_comb begin
        next_sym_c = DONE;
        case (sym_c)
            SYM1:    next_sym_c = SYM2;
            SYM2:    next_sym_c = SYM3;
            default: next_sym_c = DONE;
        endcase
    end

    assign pbch_c = (sym_c != SYM2) || (k_c < 8'(SSS_LO)) || (k_c > 8'(SSS_HI));
    assign dmrs_c = (k_c[1:0] == v_c);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state                  <= IDLE;
            nid_q                  <= '0;
            nid_ok                 <= 1'b0;
            v_q                    <= '0;
            sc_cnt                 <= '0;
            data_cnt               <= '0;
            dmrs_cnt               <= '0;
            done_o                 <= 1'b0;
            abort_o                <= 1'b0;
            bus.m_axis_llr_tdata   <= '0;
            bus.m_axis_llr_tvalid  <= 1'b0;
            bus.m_axis_llr_tlast   <= 1'b0;
            bus.m_axis_dmrs_tdata  <= '0;
            bus.m_axis_dmrs_tvalid <= 1'b0;
            bus.m_axis_dmrs_idx_o  <= '0;
        end else begin
            done_o                 <= 1'b0;
            abort_o                <= 1'b0;
            bus.m_axis_llr_tvalid  <= 1'b0;
            bus.m_axis_llr_tlast   <= 1'b0;
            bus.m_axis_dmrs_tvalid <= 1'b0;

            if (N_id_valid_i) begin
                nid_q  <= N_id_i;
                nid_ok <= 1'b1;
            end

            if (state == DONE) begin
                state    <= IDLE;
                done_o   <= 1'b1;
                sc_cnt   <= '0;
                data_cnt <= '0;
                dmrs_cnt <= '0;
            end

            if (proc_c) begin
                abort_o  <= start_c && in_block_c;
                v_q      <= v_c;
                data_cnt <= dcnt_c;
                dmrs_cnt <= mcnt_c;
                if (pbch_c) begin
                    if (dmrs_c) begin
                        bus.m_axis_dmrs_tvalid <= 1'b1;
                        bus.m_axis_dmrs_tdata  <= bus.s_axis_in_tdata;
                        bus.m_axis_dmrs_idx_o  <= mcnt_c;
                        dmrs_cnt               <= mcnt_c + 8'd1;
                    end else begin
                        // MSB slices of real/imag, used directly as signed soft bits
                        bus.m_axis_llr_tvalid <= 1'b1;
                        bus.m_axis_llr_tdata  <= {bus.s_axis_in_tdata[IN_DW-1 -: LLR_DW],
                                                  bus.s_axis_in_tdata[HALF-1 -: LLR_DW]};
                        bus.m_axis_llr_tlast  <= (dcnt_c == 9'(N_DATA - 1));
                        data_cnt              <= dcnt_c + 9'd1;
                    end
                end
                if (k_c == 8'(N_SC - 1)) begin
                    sc_cnt <= '0;
                    state  <= next_sym_c;
                end else begin
                    sc_cnt <= k_c + 8'd1;
                    state  <= sym_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_pbch_re_demapper.sv
// Directed bench for pbch_re_demapper: per-cycle expectations queued at drive time, popped one cycle later.
module tb_pbch_re_demapper;
    logic       clk;
    logic       reset_ni;
    logic [9:0] N_id_i;
    logic       N_id_valid_i;
    logic       PBCH_start_i;
    logic       done_o;
    logic       abort_o;

    pbch_re_demapper_if #(.IN_DW(32), .LLR_DW(8)) bus ();

    pbch_re_demapper #(.IN_DW(32), .LLR_DW(8), .N_SC(240)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .N_id_i       (N_id_i),
        .N_id_valid_i (N_id_valid_i),
        .PBCH_start_i (PBCH_start_i),
        .bus          (bus),
        .done_o       (done_o),
        .abort_o      (abort_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        llr_v;
        logic [15:0] llr_d;
        logic        last;
        logic        dmrs_v;
        logic [31:0] dmrs_d;
        logic [7:0]  idx;
        logic        done;
        logic        abort;
    } exp_t;

    exp_t q[$];
    int total = 0, passed = 0, failed = 0;
    int n_llr, n_dmrs, n_last, n_done, n_abort;

    // Reference model state
    bit         m_active, m_nidok, m_done_pend;
    int         m_sym, m_k, m_v, m_dc, m_mc;
    logic [9:0] m_nid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("llr_tvalid", 32'(bus.m_axis_llr_tvalid), 32'(e.llr_v));
        chk("dmrs_tvalid", 32'(bus.m_axis_dmrs_tvalid), 32'(e.dmrs_v));
        chk("done_o", 32'(done_o), 32'(e.done));
        chk("abort_o", 32'(abort_o), 32'(e.abort));
        if (e.llr_v) begin
            chk("llr_tdata", 32'(bus.m_axis_llr_tdata), 32'(e.llr_d));
            chk("llr_tlast", 32'(bus.m_axis_llr_tlast), 32'(e.last));
        end
        if (e.dmrs_v) begin
            chk("dmrs_tdata", bus.m_axis_dmrs_tdata, e.dmrs_d);
            chk("dmrs_idx", 32'(bus.m_axis_dmrs_idx_o), 32'(e.idx));
        end
        if (e.rst) begin
            chk("rst_llr_tdata", 32'(bus.m_axis_llr_tdata), 32'h0);
            chk("rst_llr_tlast", 32'(bus.m_axis_llr_tlast), 32'h0);
            chk("rst_dmrs_tdata", bus.m_axis_dmrs_tdata, 32'h0);
            chk("rst_dmrs_idx", 32'(bus.m_axis_dmrs_idx_o), 32'h0);
        end
        if (bus.m_axis_llr_tvalid === 1'b1) n_llr++;
        if (bus.m_axis_llr_tvalid === 1'b1 && bus.m_axis_llr_tlast === 1'b1) n_last++;
        if (bus.m_axis_dmrs_tvalid === 1'b1) n_dmrs++;
        if (done_o === 1'b1) n_done++;
        if (abort_o === 1'b1) n_abort++;
    endtask

    task automatic step(input bit rst_n, input bit nidv, input logic [9:0] nid,
                        input bit start, input bit vld, input logic [31:0] dat);
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) compare(q.pop_front());
        reset_ni             = rst_n;
        N_id_valid_i         = nidv;
        N_id_i               = nid;
        PBCH_start_i         = start;
        bus.s_axis_in_tvalid = vld;
        bus.s_axis_in_tdata  = dat;

        e = '0;
        if (!rst_n) begin
            e.rst       = 1'b1;
            m_active    = 1'b0;
            m_nidok     = 1'b0;
            m_nid       = '0;
            m_done_pend = 1'b0;
        end else begin
            e.done      = m_done_pend;
            m_done_pend = 1'b0;
            if (vld && start && m_nidok) begin
                e.abort  = m_active;
                m_active = 1'b1;
                m_sym    = 1;
                m_k      = 0;
                m_v      = int'(m_nid) % 4;
                m_dc     = 0;
                m_mc     = 0;
            end
            if (vld && m_active) begin
                if (m_sym != 2 || m_k < 48 || m_k >= 192) begin
                    if (m_k % 4 == m_v) begin
                        e.dmrs_v = 1'b1;
                        e.dmrs_d = dat;
                        e.idx    = 8'(m_mc);
                        m_mc++;
                    end else begin
                        e.llr_v = 1'b1;
                        e.llr_d = {dat[31:24], dat[15:8]};
                        e.last  = (m_dc == 431);
                        m_dc++;
                    end
                end
                m_k++;
                if (m_k == 240) begin
                    m_k = 0;
                    m_sym++;
                    if (m_sym == 4) begin
                        m_active    = 1'b0;
                        m_done_pend = 1'b1;
                    end
                end
            end
            if (nidv) begin
                m_nid   = nid;
                m_nidok = 1'b1;
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 32'($urandom));
    endtask

    task automatic set_nid(input logic [9:0] nid);
        step(1'b1, 1'b1, nid, 1'b0, 1'b0, 32'h0);
    endtask

    // n REs of a ramp (re=k, im=sym); optional start on RE 0, saturating pattern on RE 0, random gaps
    task automatic run_res(input int n, input bit first_start, input int gap_pct, input bit sat);
        logic [31:0] dat;
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
                step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 32'($urandom));
            dat = {16'(i / 240 + 1), 16'(i % 240)};
            if (sat && i == 0) dat = 32'h8000_7FFF;
            step(1'b1, 1'b0, 10'd0, first_start && i == 0, 1'b1, dat);
        end
    endtask

    task automatic clear_counts();
        n_llr = 0; n_dmrs = 0; n_last = 0; n_done = 0; n_abort = 0;
    endtask

    task automatic check_counts(input string tag, input int llr, input int dmrs,
                                input int last, input int done, input int abrt);
        chk({tag, "_llr_count"}, 32'(n_llr), 32'(llr));
        chk({tag, "_dmrs_count"}, 32'(n_dmrs), 32'(dmrs));
        chk({tag, "_tlast_count"}, 32'(n_last), 32'(last));
        chk({tag, "_done_count"}, 32'(n_done), 32'(done));
        chk({tag, "_abort_count"}, 32'(n_abort), 32'(abrt));
    endtask

    initial begin
        reset_ni             = 1'b0;
        N_id_valid_i         = 1'b0;
        N_id_i               = '0;
        PBCH_start_i         = 1'b0;
        bus.s_axis_in_tvalid = 1'b0;
        bus.s_axis_in_tdata  = '0;
        clear_counts();

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 32'h0);
        idle(1);

        // Start before any N_id: nothing comes out
        clear_counts();
        run_res(5, 1'b1, 0, 1'b0);
        idle(2);
        check_counts("no_nid", 0, 0, 0, 0, 0);

        // N_id=0, gap-free block
        set_nid(10'd0);
        idle(1);
        clear_counts();
        run_res(720, 1'b1, 0, 1'b0);
        idle(3);
        check_counts("v0_block", 432, 144, 1, 1, 0);

        // N_id=1007 (v=3), first RE is a data RE carrying the saturating pattern
        set_nid(10'd1007);
        idle(1);
        clear_counts();
        run_res(720, 1'b1, 0, 1'b1);
        idle(3);
        check_counts("v3_block", 432, 144, 1, 1, 0);

        // Random valid gaps
        clear_counts();
        run_res(720, 1'b1, 50, 1'b0);
        idle(3);
        check_counts("gap_block", 432, 144, 1, 1, 0);

        // Restart at sym2 k=100 (RE 340)
        run_res(340, 1'b1, 0, 1'b0);
        idle(1);
        clear_counts();
        run_res(720, 1'b1, 0, 1'b0);
        idle(3);
        check_counts("abort_block", 432, 144, 1, 1, 1);

        // Reset at sym1 k=50; later starts ignored until N_id is re-sent
        clear_counts();
        run_res(50, 1'b1, 0, 1'b0);
        step(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 32'h1234_5678);
        run_res(30, 1'b1, 0, 1'b0);
        idle(3);
        check_counts("reset_mid", 38, 12, 0, 0, 0);
        set_nid(10'd1007);
        idle(1);
        clear_counts();
        run_res(720, 1'b1, 0, 1'b0);
        idle(3);
        check_counts("post_reset", 432, 144, 1, 1, 0);

        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pbch_re_demapper.md
Name: pbch_re_demapper

Overview:
- Sits downstream of FFT_demod, in parallel with channel_estimator, on the PBCH path of the receiver.
- Consumes the 240-subcarrier SSB frequency-domain stream for SSB symbols 1..3.
- Uses the cell N_id to separate PBCH DMRS REs from PBCH data REs and drops SSS and guard REs.
- Emits data REs as soft-bit (LLR) pairs for the future PBCH decoder, and DMRS REs with their index for channel estimation.

Parameters:
- IN_DW, 32, input RE width; real in [IN_DW/2-1:0], imag in [IN_DW-1:IN_DW/2], signed.
- LLR_DW, 8, width of each soft bit; must satisfy LLR_DW <= IN_DW/2.
- N_SC, 240, subcarriers per SSB symbol; fixed by the standard and not intended to change.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  synchronous active-low reset.
- N_id_i  in  10  physical cell id.
- N_id_valid_i  in  1  one-cycle strobe; latches N_id_i.
- PBCH_start_i  in  1  pulse coincident with the first valid RE of SSB symbol 1.
- s_axis_in_tdata  in  IN_DW  RE, subcarrier order 0..239.
- s_axis_in_tvalid  in  1  RE valid; no backpressure.
- m_axis_llr_tdata  out  2*LLR_DW  {LLR_Q, LLR_I}, with LLR_I in the LSBs.
- m_axis_llr_tvalid  out  1  data RE valid.
- m_axis_llr_tlast  out  1  marks the 432nd data RE.
- m_axis_dmrs_tdata  out  IN_DW  raw DMRS RE.
- m_axis_dmrs_tvalid  out  1  DMRS RE valid.
- m_axis_dmrs_idx_o  out  8  DMRS index 0..143 within the SSB.
- done_o  out  1  one-cycle pulse after the last RE of symbol 3.
- abort_o  out  1  one-cycle pulse when a block is restarted mid-operation.

Behaviour:
Reset:
- All outputs 0, state IDLE, counters 0, N_id register 0, nid_ok 0.

N_id handling:
- N_id_valid_i latches N_id_i and sets nid_ok=1.
- v = N_id[1:0] (N_id mod 4) is computed from the latched value.
- A new N_id_valid_i while a block is in progress updates the register, but v is only sampled at PBCH_start_i.

Counters:
- sc_cnt: 0..239, advances only on s_axis_in_tvalid.
- sym: 1..3.
- data_cnt: 0..431.
- dmrs_cnt: 0..143.

State machine:
- IDLE -> SYM1 on PBCH_start_i && s_axis_in_tvalid && nid_ok. The starting RE is processed as sc 0.
- PBCH_start_i with nid_ok=0 is ignored; state stays IDLE and no outputs are produced.
- SYM1 -> SYM2 -> SYM3 on each valid RE with sc_cnt==239; sc_cnt wraps to 0.
- SYM3 with sc_cnt==239 -> DONE. DONE lasts one cycle, asserts done_o, then -> IDLE.
- PBCH_start_i in SYM1/SYM2/SYM3: abort_o pulses, all counters clear, v is re-sampled, and the current RE is treated as sc 0 of a new SYM1.
- PBCH_start_i while in DONE is treated as IDLE -> SYM1 and does not raise abort_o.

RE classification, per valid RE at subcarrier k:
- PBCH region: symbols 1 and 3 use all k. Symbol 2 uses k<=47 or k>=192; REs with 48<=k<=191 (SSS + guard) are dropped.
- Within the PBCH region, k mod 4 == v is DMRS; otherwise data.
- Per SSB: symbol 1 gives 60 DMRS / 180 data, symbol 2 gives 24 / 72, symbol 3 gives 60 / 180. Totals are 144 DMRS and 432 data.

LLR arithmetic:
- LLR_I = re[IN_DW/2-1 -: LLR_DW] and LLR_Q = im[IN_DW/2-1 -: LLR_DW], taking the MSB slice as a signed value.
- No rounding and no saturation.
- Positive LLR means bit 0.

Timing and strobes:
- Latency is one clock from input RE to its output strobe; all outputs are registered.
- At most one of m_axis_llr_tvalid / m_axis_dmrs_tvalid is high per cycle.
- m_axis_llr_tlast is asserted with data RE data_cnt==431.
- m_axis_dmrs_idx_o is valid only with m_axis_dmrs_tvalid.
- done_o asserts one cycle after the final output strobe.

Other rules:
- Valid gaps (s_axis_in_tvalid low) are allowed anywhere; counters hold during gaps.
- Input with tvalid high in IDLE without PBCH_start_i is discarded.
- Reset asserted mid-block returns to IDLE with no done_o or abort_o. nid_ok clears, so N_id must be re-delivered.

Test Plan:
- N_id=0 (v=0), then a 720-RE ramp (re=k, im=sym) with PBCH_start_i on the first RE -> 432 llr strobes, 144 dmrs strobes, and tlast on the 432nd llr. The first DMRS is the sym1 k=0 RE; the first llr is sym1 k=1. done_o pulses once, one cycle after the last strobe.
- N_id=1007 (v=3), sym2 only -> DMRS at k=3,7,..,47,195,..,239 (24 strobes, idx 60..83); k=48..191 produce no strobes; 72 llr strobes.
- IN_DW=32, LLR_DW=8, RE re=16'h7FFF, im=16'h8000 on a data position -> m_axis_llr_tdata = {8'h80, 8'h7F}, appearing exactly one cycle after the input.
- Random tvalid gaps (50% duty) across a full block -> strobe counts and order identical to the gap-free run, and tlast is still on the 432nd llr.
- PBCH_start_i asserted again at sym2 k=100 -> abort_o pulses, and the restarted block emits a full 432/144 with dmrs idx restarting at 0. PBCH_start_i before any N_id_valid_i -> no outputs.
- reset_ni low for 1 cycle at sym1 k=50 -> all outputs 0 next cycle and no done_o. A later PBCH_start_i is ignored until N_id_valid_i is re-sent.
